// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/response bus
//
// Carries one fetch request channel and one response channel.
//   req    : request valid (fetch side drives)
//   addr   : request address, word aligned (fetch side drives)
//   ready  : memory accepts the request this cycle when req=1 (memory drives)
//   rvalid : response valid, exactly one per accepted request (memory drives)
//   rdata  : response instruction word (memory drives)
// master = fetch unit, slave = instruction memory.

interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32I instruction-fetch stage with single-outstanding imem requests
//
// Owns the PC, fetches one instruction at a time from a variable-latency
// instruction memory and presents it to the IF/ID register.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   stall        : hazard unit holds the fetch output
//   redirect     : branch/jump taken; squash in-flight work and refetch
//   redirect_pc  : redirect target, low two bits forced to zero
//   imem         : instruction-memory bus (master side)
//   inst_out     : instruction to IF/ID (NOP_INST when not valid)
//   pc_out       : PC of inst_out
//   inst_valid   : inst_out is a real instruction

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            inst_out,
    output logic [31:0]            pc_out,
    output logic                   inst_valid
);

    // REQ   : issuing a request for pc
    // WAIT  : one request outstanding, response still wanted
    // HOLD  : response captured while stalled, waiting to hand it over
    // DRAIN : request outstanding but squashed; its response is thrown away
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] hold_inst;
    logic [31:0] hold_next;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] deliver_inst;

    assign target = redirect_pc & ~32'h0000_0003;
    assign pc_inc = pc + 32'd4;

    // A redirect in REQ suppresses the request so the stale pc is never fetched.
    assign imem.req  = !rst && (state == S_REQ) && !redirect;
    assign imem.addr = pc;

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        hold_next    = hold_inst;
        deliver      = 1'b0;
        deliver_inst = NOP_INST;

        case (state)
            S_REQ: begin
                if (redirect) begin
                    pc_next = target;
                end else if (imem.ready) begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = imem.rvalid ? S_REQ : S_DRAIN;
                end else if (imem.rvalid) begin
                    if (!stall) begin
                        deliver      = 1'b1;
                        deliver_inst = imem.rdata;
                        pc_next      = pc_inc;
                        state_next   = S_REQ;
                    end else begin
                        hold_next  = imem.rdata;
                        state_next = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    hold_next  = 32'h0;
                    state_next = S_REQ;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_inst;
                    pc_next      = pc_inc;
                    state_next   = S_REQ;
                end
            end

            S_DRAIN: begin
                if (redirect) begin
                    pc_next = target;
                end
                // The squashed response may coincide with a further redirect;
                // it still retires the outstanding request, otherwise the
                // unit would wait forever for a response that never comes.
                if (imem.rvalid) begin
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            hold_inst <= 32'h0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            hold_inst <= hold_next;
        end
    end

    // Output register: redirect squashes, a delivery loads, an unstalled
    // cycle without delivery inserts a bubble, a stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_out   <= NOP_INST;
            pc_out     <= 32'h0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (deliver) begin
            inst_out   <= deliver_inst;
            pc_out     <= pc;
            inst_valid <= 1'b1;
        end else if (!stall) begin
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit

module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;

    if_fetch_unit_if imem();

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: the next PC to fetch, whether a wanted instruction is
    // waiting to be handed over, and what IF/ID should currently show.
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_pcout;
    logic        exp_valid;
    bit          avail;

    // Memory environment: one outstanding request, response after cnt cycles.
    bit          outstanding;
    bit          out_live;
    int          cnt;
    logic [31:0] out_addr;
    logic [31:0] last_addr;
    int          lat_fix;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_00A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc      = RESET_PC;
        exp_inst    = NOP;
        exp_pcout   = 32'h0;
        exp_valid   = 1'b0;
        avail       = 1'b0;
        outstanding = 1'b0;
        out_live    = 1'b0;
        cnt         = 0;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next.
    task automatic step(input bit s, input bit r, input logic [31:0] t, input bit rdy);
        bit          rv;
        bit          acc;
        bit          exp_req;
        logic [31:0] tgt;
        stall       = s;
        redirect    = r;
        redirect_pc = t;
        imem.ready  = rdy;
        rv          = outstanding && (cnt == 1);
        imem.rvalid = rv;
        imem.rdata  = rv ? mem_word(out_addr) : $urandom;
        #2;
        exp_req = !r && !outstanding && !avail;
        chk("req", {31'h0, imem.req}, {31'h0, exp_req});
        if (imem.req) begin
            chk("addr", imem.addr, exp_pc);
            last_addr = imem.addr;
        end
        acc = imem.req && rdy;
        @(posedge clk);
        #1;
        tgt = {t[31:2], 2'b00};
        if (r) begin
            exp_pc    = tgt;
            avail     = 1'b0;
            if (outstanding && !rv) out_live = 1'b0;
            exp_inst  = NOP;
            exp_valid = 1'b0;
        end else begin
            if (rv && out_live) avail = 1'b1;
            if (!s) begin
                if (avail) begin
                    exp_inst  = mem_word(exp_pc);
                    exp_pcout = exp_pc;
                    exp_valid = 1'b1;
                    exp_pc    = exp_pc + 32'd4;
                    avail     = 1'b0;
                end else begin
                    exp_inst  = NOP;
                    exp_valid = 1'b0;
                end
            end
        end
        if (rv) begin
            outstanding = 1'b0;
            out_live    = 1'b0;
        end else if (outstanding) begin
            cnt--;
        end
        if (acc) begin
            outstanding = 1'b1;
            out_live    = 1'b1;
            cnt         = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
            out_addr    = last_addr;
        end
        chk("inst_out", inst_out, exp_inst);
        chk("pc_out", pc_out, exp_pcout);
        chk("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
    endtask

    task automatic async_reset();
        #2;
        rst         = 1'b1;
        imem.rvalid = 1'b0;
        #1;
        chk("arst_inst", inst_out, NOP);
        chk("arst_pc_out", pc_out, 32'h0);
        chk("arst_valid", {31'h0, inst_valid}, 32'h0);
        chk("arst_req", {31'h0, imem.req}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem.ready  = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        last_addr   = 32'h0;
        out_addr    = 32'h0;
        lat_fix     = 1;
        model_reset();

        @(posedge clk);
        #1;
        chk("rst_inst", inst_out, NOP);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_req", {31'h0, imem.req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back fetch, one instruction every two cycles.
        repeat (6) step(0, 0, 32'h0, 1);
        chk("seq_pc", pc_out, 32'h8);
        chk("seq_valid", {31'h0, inst_valid}, 32'h1);

        // Memory not ready: request held at the same address.
        repeat (3) step(0, 0, 32'h0, 0);
        chk("notready_inst", inst_out, NOP);
        chk("notready_addr", last_addr, 32'hC);
        step(0, 0, 32'h0, 1);

        // Redirect meeting a response in WAIT, then stall captures DEADBEEF.
        step(0, 1, 32'h201, 1);
        step(0, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        chk("hold_data", inst_out, 32'hDEAD_BEEF);
        chk("hold_pc", pc_out, 32'h200);
        step(0, 0, 32'h0, 0);
        chk("after_hold_addr", last_addr, 32'h204);

        // Redirect while waiting; the late response must be drained.
        lat_fix = 3;
        step(0, 0, 32'h0, 1);
        step(0, 1, 32'h103, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        chk("drain_valid", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 32'h0, 0);
        chk("redir_addr", last_addr, 32'h100);

        // Redirect during HOLD with stall still high.
        lat_fix = 1;
        step(0, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        step(1, 1, 32'h300, 1);
        chk("hold_redir_inst", inst_out, NOP);
        chk("hold_redir_valid", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 32'h0, 0);
        chk("hold_redir_addr", last_addr, 32'h300);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFF, 0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 0);
        chk("wrap_addr", last_addr, 32'h0);

        // Asynchronous reset with a request outstanding.
        redirect = 1'b0;
        lat_fix  = 3;
        step(0, 0, 32'h10, 1);
        step(0, 1, 32'h40, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        async_reset();
        step(0, 0, 32'h0, 0);
        chk("post_rst_addr", last_addr, RESET_PC);

        // Randomised traffic against the reference.
        lat_fix = 0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t;
            t = (($urandom % 4) == 0) ? (32'hFFFF_FFF8 | ($urandom % 8)) : $urandom;
            step(($urandom % 4) == 0, ($urandom % 16) == 0, t, ($urandom % 4) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID pipeline register. It owns the PC and issues single-outstanding requests to an instruction memory with variable response latency. It presents {inst_out, pc_out, inst_valid} to IF/ID. It honours pipeline stall from the hazard unit and redirect from the branch/jump resolution logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid instruction.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold fetch output (hazard unit)
redirect  in  1  branch/jump taken; squash and refetch
redirect_pc  in  32  target PC; bits[1:0] ignored, forced to 0
imem_req  out  1  request valid (combinational from state/redirect)
imem_addr  out  32  request address = pc
imem_ready  in  1  memory accepts request this cycle when imem_req=1
imem_rvalid  in  1  response valid, one response per accepted request
imem_rdata  in  32  response instruction
inst_out  out  32  fetched instruction to IF/ID
pc_out  out  32  PC of inst_out
inst_valid  out  1  inst_out is a real instruction, not a bubble

Behaviour:
- Reset (async): pc=RESET_PC, state=REQ, inst_out=NOP_INST, pc_out=0, inst_valid=0, hold buffer cleared. imem_req=0 while rst=1.
- States: REQ (issue), WAIT (one request outstanding), HOLD (instruction captured, output stalled), DRAIN (outstanding response to discard).
- REQ: imem_req=!redirect, imem_addr=pc.
  - redirect: pc<=redirect_pc, stay REQ, no request issued.
  - else imem_ready: ->WAIT.
  - else: stay REQ.
- WAIT: imem_req=0.
  - redirect & rvalid: discard data, pc<=redirect_pc, ->REQ.
  - redirect & !rvalid: pc<=redirect_pc, ->DRAIN.
  - rvalid & !stall: inst_out<=rdata, pc_out<=pc, inst_valid<=1, pc<=pc+4, ->REQ.
  - rvalid & stall: hold_inst<=rdata, ->HOLD.
- HOLD: imem_req=0.
  - redirect: discard hold, pc<=redirect_pc, ->REQ.
  - !stall: inst_out<=hold_inst, pc_out<=pc, inst_valid<=1, pc<=pc+4, ->REQ.
- DRAIN: imem_req=0.
  - redirect: pc<=redirect_pc, stay DRAIN.
  - rvalid: discard, ->REQ.
- Output register rules:
  - stall=1 and redirect=0: inst_out/pc_out/inst_valid hold.
  - stall=0 and no instruction delivered this edge: inst_out<=NOP_INST, inst_valid<=0, pc_out holds.
  - redirect=1 (priority over stall): inst_out<=NOP_INST, inst_valid<=0 on that edge.
- pc+4 wraps modulo 2^32. imem_rvalid in REQ or HOLD is a protocol violation and is ignored.
- Latency: with imem_ready=1 and rvalid one cycle after acceptance, an instruction is delivered every 2 cycles. Output is valid the edge after rvalid.
- Asynchronous reset mid-operation abandons any outstanding request. The memory model must drop it.

Test Plan:
- Reset release, imem_ready=1, rvalid 1 cycle after accept, rdata=PC-tagged words -> imem_addr sequence 0x0,0x4,0x8. Each inst_valid=1 with pc_out matching, one instruction per 2 cycles.
- imem_ready=0 for 3 cycles in REQ -> imem_addr stays 0x0, inst_valid=0, inst_out=0x00000013. Request issued when ready rises.
- stall=1 asserted during WAIT, rvalid with 0xDEADBEEF -> outputs unchanged, state HOLD. Stall releases -> inst_out=0xDEADBEEF, next imem_addr=pc+4.
- redirect to 0x0000_0103 while WAIT, rvalid 2 cycles later -> response discarded, inst_valid=0. Next imem_addr=0x0000_0100.
- redirect and rvalid same cycle in WAIT, and redirect with stall=1 in HOLD -> data discarded, inst_out=NOP_INST, next request at redirect target.
- pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000. Async rst pulse mid-WAIT -> pc=RESET_PC, outputs at reset values immediately.
